// File: rtl/seg_display_arbiter_pkg.sv
// Shared state encoding, display limit and clamp helper for the display arbiter.
// Pure definitions: no latency, no flow control.
package seg_display_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } arb_state_e;

    localparam int DISP_MAX = 9999;

    function automatic logic [15:0] clamp_val(input logic [15:0] v, input logic [15:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Round-robin picker: first asserted request after last_owner, optionally skipping one index.
// Combinational, zero latency; no backpressure.
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_owner,
    input  logic             excl_en,
    input  logic [IW-1:0]    excl_idx,
    output logic             found,
    output logic [IW-1:0]    idx
);

    logic [N_REQ-1:0] cand;
    logic [IW-1:0]    pos;

    // Walk from the farthest slot back to last_owner+1 so the nearest hit is written last.
    always_comb begin
        cand = req;
        if (excl_en) cand[excl_idx] = 1'b0;
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            pos = IW'((int'(last_owner) + k) % N_REQ);
            if (cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 4-digit display between N_REQ requesters: round-robin, minimum hold, blank gap.
// Latency: grant 1 cycle after req, value visible BLANK_CYCLES later; no backpressure, req is level-held.
module seg_display_arbiter
    import seg_display_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int HOLD_CYCLES  = 8,
    parameter int BLANK_CYCLES = 2,
    parameter int MAX_VAL      = DISP_MAX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [16*N_REQ-1:0] req_val,
    output logic [15:0]         disp_val,
    output logic                disp_blank,
    output logic [N_REQ-1:0]    grant,
    output logic                busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    arb_state_e       state_q;
    logic [IW-1:0]    owner_q;
    logic [HW-1:0]    hold_cnt_q;
    logic [BW-1:0]    blank_cnt_q;
    logic [15:0]      disp_val_q;
    logic             disp_blank_q;
    logic [N_REQ-1:0] grant_q;
    logic             busy_q;

    logic [15:0]      sel_val;
    logic [15:0]      disp_val_d;
    logic             owner_req;
    logic             hold_sat;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IW'(i)) sel_val = req_val[16*i +: 16];
        end
    end

    assign disp_val_d = clamp_val(sel_val, 16'(MAX_VAL));
    assign owner_req  = req[owner_q];
    assign hold_sat   = (hold_cnt_q == HOLD_LAST);

    // owner_q doubles as last_owner; while showing, the owner itself is not a successor.
    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (req),
        .last_owner (owner_q),
        .excl_en    (state_q == SHOW),
        .excl_idx   (owner_q),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= IW'(N_REQ - 1);
            hold_cnt_q   <= '0;
            blank_cnt_q  <= '0;
            disp_val_q   <= '0;
            disp_blank_q <= 1'b1;
            grant_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q     <= BLANK;
                        owner_q     <= pick_idx;
                        grant_q     <= N_REQ'(1) << pick_idx;
                        blank_cnt_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                BLANK: begin
                    blank_cnt_q <= blank_cnt_q + 1'b1;
                    if (!owner_req) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (blank_cnt_q == BLANK_LAST) begin
                        state_q      <= SHOW;
                        hold_cnt_q   <= '0;
                        disp_blank_q <= 1'b0;
                        disp_val_q   <= disp_val_d;
                    end
                end
                SHOW: begin
                    if (!hold_sat) hold_cnt_q <= hold_cnt_q + 1'b1;
                    if (!owner_req && !pick_found) begin
                        state_q      <= IDLE;
                        disp_blank_q <= 1'b1;
                        grant_q      <= '0;
                        busy_q       <= 1'b0;
                    end else if (pick_found && (!owner_req || hold_sat)) begin
                        // A departing owner forfeits the rest of its hold time.
                        state_q      <= BLANK;
                        owner_q      <= pick_idx;
                        grant_q      <= N_REQ'(1) << pick_idx;
                        blank_cnt_q  <= '0;
                        disp_blank_q <= 1'b1;
                    end else begin
                        disp_val_q <= disp_val_d;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    disp_blank_q <= 1'b1;
                    grant_q      <= '0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign disp_val   = disp_val_q;
    assign disp_blank = disp_blank_q;
    assign grant      = grant_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with N_REQ=4, HOLD_CYCLES=8, BLANK_CYCLES=2.
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_val;
    logic [15:0] disp_val;
    logic        disp_blank;
    logic [3:0]  grant;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg_display_arbiter #(
        .N_REQ        (4),
        .HOLD_CYCLES  (8),
        .BLANK_CYCLES (2),
        .MAX_VAL      (9999)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_val    (req_val),
        .disp_val   (disp_val),
        .disp_blank (disp_blank),
        .grant      (grant),
        .busy       (busy)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic exp_blank, input logic [3:0] exp_grant,
                             input logic exp_busy, input logic [15:0] exp_val);
        check_val({tag, ".blank"}, 16'(disp_blank), 16'(exp_blank));
        check_val({tag, ".grant"}, 16'(grant), 16'(exp_grant));
        check_val({tag, ".busy"},  16'(busy), 16'(exp_busy));
        check_val({tag, ".val"},   disp_val, exp_val);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_val(input int i, input logic [15:0] v);
        req_val[16*i +: 16] = v;
    endtask

    initial begin
        reset   = 1'b1;
        req     = 4'hF;
        req_val = '0;
        set_val(0, 16'd111);
        set_val(1, 16'd222);

        // Reset dominates even with every requester asserted.
        for (int c = 0; c < 3; c++) begin
            tick();
            check_out("reset_hold", 1'b1, 4'b0000, 1'b0, 16'd0);
        end
        reset = 1'b0;
        req   = 4'b0000;
        tick();
        check_out("idle", 1'b1, 4'b0000, 1'b0, 16'd0);

        // Single requester 2 from IDLE.
        set_val(2, 16'd1234);
        req = 4'b0100;
        tick();
        check_out("r2_c1", 1'b1, 4'b0100, 1'b1, 16'd0);
        tick();
        check_out("r2_c2", 1'b1, 4'b0100, 1'b1, 16'd0);
        tick();
        check_out("r2_c3", 1'b0, 4'b0100, 1'b1, 16'd1234);
        for (int c = 0; c < 12; c++) tick();
        check_out("r2_lone", 1'b0, 4'b0100, 1'b1, 16'd1234);
        req = 4'b0000;
        tick();
        check_out("r2_drop", 1'b1, 4'b0000, 1'b0, 16'd1234);

        // Two requesters: hold then hand-over with clamp.
        set_val(0, 16'd5);
        set_val(1, 16'd12000);
        req = 4'b0011;
        tick();
        check_out("rr_b1", 1'b1, 4'b0001, 1'b1, 16'd1234);
        tick();
        check_out("rr_b2", 1'b1, 4'b0001, 1'b1, 16'd1234);
        for (int c = 0; c < 8; c++) begin
            tick();
            check_out("rr_show0", 1'b0, 4'b0001, 1'b1, 16'd5);
        end
        tick();
        check_out("rr_gap1", 1'b1, 4'b0010, 1'b1, 16'd5);
        tick();
        check_out("rr_gap2", 1'b1, 4'b0010, 1'b1, 16'd5);
        tick();
        check_out("rr_show1", 1'b0, 4'b0010, 1'b1, 16'd9999);

        // Owner 1 leaves at hold 0: waived hold, requester 0 takes over.
        req = 4'b0001;
        tick();
        check_out("waive_b1", 1'b1, 4'b0001, 1'b1, 16'd9999);
        tick();
        tick();
        check_out("waive_show", 1'b0, 4'b0001, 1'b1, 16'd5);

        // Value tracking with one cycle of latency, plus clamp edges.
        set_val(0, 16'd42);
        tick();
        check_val("trk42", disp_val, 16'd42);
        set_val(0, 16'd43);
        check_val("trk43_pre", disp_val, 16'd42);
        tick();
        check_val("trk43", disp_val, 16'd43);
        set_val(0, 16'hFFFF);
        tick();
        check_val("clamp_ffff", disp_val, 16'd9999);
        set_val(0, 16'd10000);
        tick();
        check_val("clamp_10000", disp_val, 16'd9999);
        set_val(0, 16'd9998);
        tick();
        check_val("clamp_9998", disp_val, 16'd9998);
        req = 4'b0000;
        tick();
        check_out("trk_idle", 1'b1, 4'b0000, 1'b0, 16'd9998);

        // Owner 0 drops at hold_cnt 3 with no other request.
        set_val(0, 16'd7);
        req = 4'b0001;
        tick();
        tick();
        tick();
        check_out("d3a_show", 1'b0, 4'b0001, 1'b1, 16'd7);
        tick();
        tick();
        tick();
        req = 4'b0000;
        tick();
        check_out("d3a_idle", 1'b1, 4'b0000, 1'b0, 16'd7);

        // Owner 0 drops at hold_cnt 3 while requester 3 waits.
        req = 4'b0001;
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();
        req = 4'b1000;
        tick();
        check_out("d3b_handover", 1'b1, 4'b1000, 1'b1, 16'd7);
        req = 4'b0000;
        tick();
        check_out("blank_drop", 1'b1, 4'b0000, 1'b0, 16'd7);

        // Reset during SHOW of owner 2, then reset order restarts at requester 0.
        set_val(2, 16'd321);
        req = 4'b0100;
        tick();
        tick();
        tick();
        check_out("rst_show2", 1'b0, 4'b0100, 1'b1, 16'd321);
        req = 4'b0101;
        tick();
        check_out("rst_pre", 1'b0, 4'b0100, 1'b1, 16'd321);
        reset = 1'b1;
        tick();
        check_out("rst_pulse", 1'b1, 4'b0000, 1'b0, 16'd0);
        reset = 1'b0;
        tick();
        check_out("rst_first", 1'b1, 4'b0001, 1'b1, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
